// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control unit: opcodes,
// FSM states, instruction classes and datapath select codes.
package proc_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_PCUP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_t;

    localparam logic [1:0] OPM_REG   = 2'b00;
    localparam logic [1:0] OPM_IMM   = 2'b01;
    localparam logic [1:0] OPM_LOAD  = 2'b10;
    localparam logic [1:0] OPM_STORE = 2'b11;

    localparam logic [2:0] SEL_BEQ  = 3'd0;
    localparam logic [2:0] SEL_BNE  = 3'd1;
    localparam logic [2:0] SEL_BLT  = 3'd2;
    localparam logic [2:0] SEL_BGE  = 3'd3;
    localparam logic [2:0] SEL_BLTU = 3'd4;
    localparam logic [2:0] SEL_BGEU = 3'd5;
    // Constant-0 flag: PC always takes the +1 path.
    localparam logic [2:0] SEL_ZERO = 3'd7;

    function automatic logic [2:0] branch_sel(input logic [2:0] f3);
        logic [2:0] sel;
        case (f3)
            3'b000:  sel = SEL_BEQ;
            3'b001:  sel = SEL_BNE;
            3'b100:  sel = SEL_BLT;
            3'b101:  sel = SEL_BGE;
            3'b110:  sel = SEL_BLTU;
            3'b111:  sel = SEL_BGEU;
            default: sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/proc_control_fsm_decoder.sv
// Combinational instruction decoder: maps opcode/funct fields to instruction
// class, ALU mode, operand path and branch flag select.
module ctrl_decoder
    import proc_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    output instr_class_t instr_class,
    output logic         add_sub,
    output logic [1:0]   op_mem_i,
    output logic [2:0]   select_flags,
    output logic         illegal
);

    always_comb begin
        instr_class  = CLS_ILLEGAL;
        add_sub      = 1'b0;
        op_mem_i     = OPM_REG;
        select_flags = SEL_ZERO;
        case (opcode)
            OPC_R: begin
                instr_class = CLS_ALU;
                add_sub     = (funct3 == 3'b000) && funct7_5;
            end
            OPC_I_ALU: begin
                instr_class = CLS_ALU;
                op_mem_i    = OPM_IMM;
            end
            OPC_LOAD: begin
                instr_class = CLS_LOAD;
                op_mem_i    = OPM_LOAD;
            end
            OPC_STORE: begin
                instr_class = CLS_STORE;
                op_mem_i    = OPM_STORE;
            end
            OPC_BRANCH: begin
                // funct3 010/011 have no branch meaning and stay illegal
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    instr_class  = CLS_BRANCH;
                    add_sub      = 1'b1;
                    select_flags = branch_sel(funct3);
                end
            end
            default: ;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: steps each instruction through FETCH/EXEC/(MEM)/PCUP
// and drives the datapath strobes and selects as Moore outputs.
//
//   state | meaning
//   IDLE  | parked, no strobes; leaves when run=1
//   FETCH | latch instruction fields, decode for legality
//   EXEC  | ALU/store strobe; loads continue to MEM
//   MEM   | load writeback into register file
//   PCUP  | PC load, retire count; continue or park on run
//   HALT  | illegal instruction seen; only reset leaves
module proc_control_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic             WE_reg,
    output logic             WE_mem,
    output logic [1:0]       OP_MEM_I,
    output logic             ADD_SUB,
    output logic             PC_load,
    output logic [2:0]       select_flags,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t       state;
    state_t       state_nxt;
    logic [6:0]   opcode_q;
    logic [2:0]   funct3_q;
    logic         funct7_5_q;
    logic [6:0]   dec_opcode;
    logic [2:0]   dec_funct3;
    logic         dec_funct7_5;
    instr_class_t dec_class;
    logic         dec_add_sub;
    logic [1:0]   dec_op_mem_i;
    logic [2:0]   dec_select_flags;
    logic         dec_illegal;

    // During FETCH the fields being latched are decoded directly so the
    // legality decision is made in the same cycle; later states use the copy.
    assign dec_opcode   = (state == S_FETCH) ? opcode   : opcode_q;
    assign dec_funct3   = (state == S_FETCH) ? funct3   : funct3_q;
    assign dec_funct7_5 = (state == S_FETCH) ? funct7_5 : funct7_5_q;

    ctrl_decoder u_decoder (
        .opcode       (dec_opcode),
        .funct3       (dec_funct3),
        .funct7_5     (dec_funct7_5),
        .instr_class  (dec_class),
        .add_sub      (dec_add_sub),
        .op_mem_i     (dec_op_mem_i),
        .select_flags (dec_select_flags),
        .illegal      (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_5_q  <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state == S_FETCH) begin
                opcode_q   <= opcode;
                funct3_q   <= funct3;
                funct7_5_q <= funct7_5;
            end
            if (state == S_PCUP) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = run ? S_FETCH : S_IDLE;
            S_FETCH: state_nxt = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC:  state_nxt = (dec_class == CLS_LOAD) ? S_MEM : S_PCUP;
            S_MEM:   state_nxt = S_PCUP;
            S_PCUP:  state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset forces reset values immediately so no strobe leaks in the reset cycle.
    always_comb begin
        WE_reg       = 1'b0;
        WE_mem       = 1'b0;
        OP_MEM_I     = OPM_REG;
        ADD_SUB      = 1'b0;
        PC_load      = 1'b0;
        select_flags = SEL_ZERO;
        busy         = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: busy = 1'b1;
                S_EXEC: begin
                    busy         = 1'b1;
                    OP_MEM_I     = dec_op_mem_i;
                    ADD_SUB      = dec_add_sub;
                    select_flags = dec_select_flags;
                    WE_reg       = (dec_class == CLS_ALU);
                    WE_mem       = (dec_class == CLS_STORE);
                end
                S_MEM: begin
                    busy         = 1'b1;
                    OP_MEM_I     = dec_op_mem_i;
                    ADD_SUB      = dec_add_sub;
                    select_flags = dec_select_flags;
                    WE_reg       = 1'b1;
                end
                S_PCUP: begin
                    busy         = 1'b1;
                    OP_MEM_I     = dec_op_mem_i;
                    ADD_SUB      = dec_add_sub;
                    select_flags = dec_select_flags;
                    PC_load      = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: expected per-cycle output vectors are
// queued as each instruction is issued and popped as the DUTs step.
module tb_proc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;

    logic        we_reg_a, we_mem_a, add_sub_a, pc_load_a, busy_a, halted_a;
    logic [1:0]  op_a;
    logic [2:0]  sel_a;
    logic [15:0] cnt_a;
    logic        we_reg_b, we_mem_b, add_sub_b, pc_load_b, busy_b, halted_b;
    logic [1:0]  op_b;
    logic [2:0]  sel_b;
    logic [3:0]  cnt_b;

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [41:0] sb[$];
    logic [41:0] e;

    proc_control_fsm dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .WE_reg(we_reg_a), .WE_mem(we_mem_a), .OP_MEM_I(op_a),
        .ADD_SUB(add_sub_a), .PC_load(pc_load_a), .select_flags(sel_a),
        .busy(busy_a), .halted(halted_a), .instr_count(cnt_a)
    );

    proc_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .WE_reg(we_reg_b), .WE_mem(we_mem_b), .OP_MEM_I(op_b),
        .ADD_SUB(add_sub_b), .PC_load(pc_load_b), .select_flags(sel_b),
        .busy(busy_b), .halted(halted_b), .instr_count(cnt_b)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] obs();
        return {busy_a, halted_a, we_reg_a, we_mem_a, pc_load_a, add_sub_a, op_a, sel_a, cnt_a,
                busy_b, halted_b, we_reg_b, we_mem_b, pc_load_b, add_sub_b, op_b, sel_b, cnt_b};
    endfunction

    function automatic logic [41:0] mk(input logic bz, input logic hl, input logic wr,
                                       input logic wm, input logic pl, input logic as,
                                       input logic [1:0] op, input logic [2:0] sel,
                                       input logic [15:0] cnt);
        logic [10:0] c;
        c = {bz, hl, wr, wm, pl, as, op, sel};
        return {c, cnt, c, cnt[3:0]};
    endfunction

    // kind: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 illegal
    task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         output int kind, output logic [1:0] op, output logic as,
                         output logic [2:0] sel);
        kind = 4; op = 2'b00; as = 1'b0; sel = 3'd7;
        case (opc)
            7'h33: begin kind = 0; as = (f3 == 3'b000) && f7; end
            7'h13: begin kind = 0; op = 2'b01; end
            7'h03: begin kind = 1; op = 2'b10; end
            7'h23: begin kind = 2; op = 2'b11; end
            7'h63: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    kind = 3;
                    as   = 1'b1;
                    case (f3)
                        3'b000:  sel = 3'd0;
                        3'b001:  sel = 3'd1;
                        3'b100:  sel = 3'd2;
                        3'b101:  sel = 3'd3;
                        3'b110:  sel = 3'd4;
                        default: sel = 3'd5;
                    endcase
                end
            end
            default: kind = 4;
        endcase
    endtask

    // Drives one instruction and queues the per-cycle expectations from FETCH on.
    task automatic start_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                               input logic run_after, output int n);
        int          kind;
        logic [1:0]  op;
        logic        as;
        logic [2:0]  sel;
        model(opc, f3, f7, kind, op, as, sel);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 3'd7, exp_cnt));
        n = 1;
        if (kind == 4) begin
            repeat (3) sb.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 3'd7, exp_cnt));
            n += 3;
        end else begin
            sb.push_back(mk(1, 0, kind == 0, kind == 2, 0, as, op, sel, exp_cnt));
            n++;
            if (kind == 1) begin
                sb.push_back(mk(1, 0, 1, 0, 0, as, op, sel, exp_cnt));
                n++;
            end
            sb.push_back(mk(1, 0, 0, 0, 1, as, op, sel, exp_cnt));
            n++;
            exp_cnt = exp_cnt + 16'd1;
            if (!run_after) begin
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, exp_cnt));
                n++;
            end
        end
        opcode = opc; funct3 = f3; funct7_5 = f7; run = 1'b1;
    endtask

    // After FETCH the live fields are garbage; only the latched copy may matter.
    task automatic mid_instr(input logic run_after);
        opcode   = 7'h7f;
        funct3   = 3'($urandom);
        funct7_5 = 1'($urandom);
        run      = run_after;
    endtask

    task automatic pick_legal(output logic [6:0] opc, output logic [2:0] f3, output logic f7);
        logic [6:0] opcs [5];
        logic [2:0] bf3 [6];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        opc  = opcs[$urandom_range(0, 4)];
        f3   = (opc == 7'h63) ? bf3[$urandom_range(0, 5)] : 3'($urandom);
        f7   = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0)) begin
            fails++; $display("FAIL reset_state: got %h expected %h", obs(), mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0));
        end
        run = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0)) begin
            fails++; $display("FAIL reset_dominates_run: got %h expected idle", obs());
        end
        reset = 1'b0; run = 1'b0; exp_cnt = 16'd0;
    endtask

    task automatic test_r_sub();
        int n;
        start_instr(7'h33, 3'b000, 1'b1, 1'b0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL r_sub step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b0);
        end
    endtask

    task automatic test_load();
        int n;
        start_instr(7'h03, 3'b010, 1'b0, 1'b0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL load step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b0);
        end
    endtask

    task automatic test_branch();
        int n;
        start_instr(7'h63, 3'b101, 1'b0, 1'b0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL branch_bge step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b0);
        end
    endtask

    task automatic test_illegal();
        int n;
        logic [6:0] opcs [2];
        logic [2:0] f3s  [2];
        opcs = '{7'h7f, 7'h63};
        f3s  = '{3'b000, 3'b010};
        for (int c = 0; c < 2; c++) begin
            start_instr(opcs[c], f3s[c], 1'b0, 1'b0, n);
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin fails++; $display("FAIL illegal%0d step %0d: got %h expected %h", c, k, obs(), e); end
                if (k == 1) mid_instr(1'b1);
            end
            reset = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0)) begin
                fails++; $display("FAIL illegal%0d_reset_exit: got %h expected idle", c, obs());
            end
            reset = 1'b0; run = 1'b0; exp_cnt = 16'd0;
        end
    endtask

    task automatic test_run_drop();
        int n;
        start_instr(7'h23, 3'b010, 1'b0, 1'b0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL run_drop_store step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b0);
        end
        start_instr(7'h13, 3'b000, 1'b1, 1'b0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL run_resume step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        for (int i = 0; i < 8; i++) begin
            pick_legal(opc, f3, f7);
            start_instr(opc, f3, f7, i != 7, n);
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin fails++; $display("FAIL b2b i%0d op %h step %0d: got %h expected %h", i, opc, k, obs(), e); end
                if (k == 1) mid_instr(i != 7);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        int n;
        start_instr(7'h03, 3'b000, 1'b0, 1'b0, n);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin fails++; $display("FAIL reset_mem_pre step %0d: got %h expected %h", k, obs(), e); end
            if (k == 1) mid_instr(1'b1);
        end
        sb.delete();
        reset = 1'b1;
        #1;
        checks++;
        if (we_reg_a !== 1'b0 || we_reg_b !== 1'b0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL reset_mem_no_strobe: got we_reg %b/%b busy %b expected 0", we_reg_a, we_reg_b, busy_a);
        end
        @(posedge clk); #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0)) begin
            fails++; $display("FAIL reset_mem_idle: got %h expected %h", obs(), mk(0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 16'd0));
        end
        reset = 1'b0; run = 1'b0; exp_cnt = 16'd0;
    endtask

    task automatic test_wrap();
        int n;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        for (int i = 0; i < 16; i++) begin
            pick_legal(opc, f3, f7);
            start_instr(opc, f3, f7, i != 15, n);
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if (obs() !== e) begin fails++; $display("FAIL wrap i%0d step %0d: got %h expected %h", i, k, obs(), e); end
                if (k == 1) mid_instr(i != 15);
            end
        end
        checks++;
        if (cnt_b !== 4'd0 || cnt_a !== 16'd16) begin
            fails++; $display("FAIL wrap_count: got cnt4 %0d cnt16 %0d expected 0 and 16", cnt_b, cnt_a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_sub();
        test_load();
        test_branch();
        test_illegal();
        test_run_drop();
        test_back_to_back();
        test_reset_in_mem();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
